// File: rtl/program_counter16.sv
// 16-bit program counter with a valid/ready fetch handshake and a one-cycle bubble after redirects.
// Define PC_RAS_EN to add a circular return-address stack with call/ret ports and the ras_err pulse.
module program_counter16 #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic             fetch_valid,
  input  logic             fetch_ready
`ifdef PC_RAS_EN
  ,
  input  logic             call,
  input  logic             ret,
  output logic             ras_err
`endif
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, BUBBLE = 2'b10} state_t;

  state_t           state;
  logic             accept;
  logic             redirect;
  logic             hold;
  logic             advance;
  logic [WIDTH-1:0] target;

  assign fetch_valid = (state == RUN);
  assign accept      = fetch_valid & fetch_ready;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    tos;      // index of the newest entry
  logic [PW-1:0]    tos_inc;
  logic [PW:0]      count;
  logic             empty, full, push, pop, err_next;

  assign tos_inc = tos + 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(RAS_DEPTH));

  always_comb begin
    pop      = ret & ~empty;
    push     = call & ~ret;
    hold     = ret & empty;   // empty ret is a no-op that also swallows load/inc
    err_next = (ret & empty) | (push & full);
    redirect = pop | push | (load & ~ret & ~call);
    target   = pop ? stack[tos] : in;
  end

  // A full push wraps onto the oldest slot, so no shifting is needed.
  always_ff @(posedge clk) begin
    if (push) stack[tos_inc] <= out + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos     <= '0;
      count   <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= err_next;
      if (pop) begin
        tos   <= tos - 1'b1;
        count <= count - 1'b1;
      end else if (push) begin
        tos <= tos_inc;
        if (!full) count <= count + 1'b1;
      end
    end
  end
`else
  always_comb begin
    hold     = 1'b0;
    redirect = load;
    target   = in;
  end
`endif

  assign advance = ~redirect & ~hold & inc & accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= RESET_ADDR;
      state <= BOOT;
    end else begin
      if (redirect)     out <= target;
      else if (advance) out <= out + 1'b1;
      state <= redirect ? BUBBLE : RUN;
    end
  end

endmodule

// File: tb/tb_program_counter16.sv
// Directed bench for program_counter16: a queue-based reference model is checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_program_counter16;

  logic        clk = 1'b0;
  logic        reset, load, inc, fetch_ready;
  logic [15:0] in;
  logic [15:0] out;
  logic        fetch_valid;
`ifdef PC_RAS_EN
  logic        call, ret, ras_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  program_counter16 dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
    .out(out), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready)
`ifdef PC_RAS_EN
    , .call(call), .ret(ret), .ras_err(ras_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC value, cycles since last reset/redirect, return stack as a queue.
  logic [15:0] m_pc;
  int          m_quiet;
  bit          m_err, m_init, acc, redir;
  logic [15:0] m_stack[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 16'h0000; m_quiet = 0; m_err = 0; m_stack.delete(); m_init = 1;
    end else begin
      acc = (m_quiet >= 1) && fetch_ready;
      redir = 0;
      m_err = 0;
`ifdef PC_RAS_EN
      if (ret) begin
        if (m_stack.size() == 0) m_err = 1;
        else begin m_pc = m_stack.pop_back(); redir = 1; end
      end else if (call) begin
        if (m_stack.size() == 4) begin void'(m_stack.pop_front()); m_err = 1; end
        m_stack.push_back(m_pc + 16'd1);
        m_pc = in; redir = 1;
      end else
`endif
      if (load) begin m_pc = in; redir = 1; end
      else if (inc && acc) m_pc = m_pc + 16'd1;
      if (redir) m_quiet = 0;
      else if (m_quiet < 1000) m_quiet++;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_out", out, m_pc);
      check("model_valid", fetch_valid, m_quiet >= 1);
`ifdef PC_RAS_EN
      check("model_ras_err", ras_err, m_err);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1; load = 0; inc = 0; fetch_ready = 0; in = 16'h0;
`ifdef PC_RAS_EN
    call = 0; ret = 0;
`endif
    cyc(2);
    reset = 0;
    check("reset_out", out, 16'h0000);
    check("reset_valid", fetch_valid, 1'b0);
    cyc(1);
    check("boot_valid", fetch_valid, 1'b1);

    fetch_ready = 1; inc = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      check("stream_out", out, i);
    end
    cyc(2);
    check("pre_stall", out, 16'h0007);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_hold", out, 16'h0007);
    end
    fetch_ready = 1;
    cyc(1);
    check("stall_release", out, 16'h0008);

    load = 1; in = 16'h1234;
    cyc(1);
    check("load_out", out, 16'h1234);
    check("load_bubble", fetch_valid, 1'b0);
    load = 0;
    cyc(1);
    check("load_valid", fetch_valid, 1'b1);
    check("load_hold", out, 16'h1234);
    cyc(1);
    check("load_next", out, 16'h1235);

    load = 1; in = 16'hFFFF;
    cyc(1);
    load = 0;
    cyc(1);
    check("wrap_pre", out, 16'hFFFF);
    cyc(1);
    check("wrap_out", out, 16'h0000);
    check("wrap_valid", fetch_valid, 1'b1);

    // reset while a redirect and its bubble are in flight
    load = 1; in = 16'hABCD;
    cyc(1);
    check("bubble_out", out, 16'hABCD);
    reset = 1; in = 16'h5555;
    cyc(1);
    check("rst_dom_out", out, 16'h0000);
    check("rst_dom_valid", fetch_valid, 1'b0);
    reset = 0; load = 0; inc = 0;
    cyc(1);
    check("rst_dom_run", fetch_valid, 1'b1);

`ifdef PC_RAS_EN
    load = 1; in = 16'h0010;
    cyc(1);
    load = 0;
    cyc(1);
    call = 1; in = 16'h0200;
    cyc(1);
    check("call_out", out, 16'h0200);
    call = 0;
    cyc(1);
    ret = 1;
    cyc(1);
    check("ret_out", out, 16'h0011);
    ret = 0;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      call = 1; in = 16'h0300 + 16'(k);
      cyc(1);
      check("nest_err", ras_err, k == 4);
    end
    call = 0;
    for (int k = 0; k < 4; k++) begin
      ret = 1;
      cyc(1);
      check("pop_out", out, 16'h0304 - 16'(k));
    end
    cyc(1);
    check("empty_hold", out, 16'h0301);
    check("empty_err", ras_err, 1'b1);
    ret = 0;
    cyc(1);
    check("err_clear", ras_err, 1'b0);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
